// File: rtl/operand_fetch.sv
// operand_fetch: decode-stage operand read with a 32-entry write scoreboard; define WB_BYPASS_EN to forward writeback data.
// Latency: exactly 1 cycle from accept to out_valid.
// Backpressure: in_ready drops on a hazard, on flush, during reset, or while a held bundle is not taken.
module operand_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  read_sel1,
  output logic [4:0]  read_sel2,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_sel,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rd
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
  } bundle_t;

  bundle_t     bundle;
  bundle_t     next_bundle;
  logic [31:0] scoreboard;
  logic [31:0] sb_next;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       writes_rd;
  logic       bypass1;
  logic       bypass2;
  logic       hazard;
  logic       accept;
  logic       issue;
  logic       wb_hit;

  assign opcode    = in_instr[6:0];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign rd        = in_instr[11:7];
  assign read_sel1 = rs1;
  assign read_sel2 = rs2;

  // x0 is never a real dependency or destination
  assign uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL) && (rs1 != 5'd0);
  assign uses_rs2  = (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH) && (rs2 != 5'd0);
  assign writes_rd = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != 5'd0);

  assign wb_hit = wb_valid && (wb_sel != 5'd0);

`ifdef WB_BYPASS_EN
  assign bypass1 = uses_rs1 && wb_hit && (wb_sel == rs1) && scoreboard[rs1];
  assign bypass2 = uses_rs2 && wb_hit && (wb_sel == rs2) && scoreboard[rs2];
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // A bit being cleared this cycle still stalls: the register file write lands at the edge
  assign hazard = (uses_rs1 && scoreboard[rs1] && !bypass1)
               || (uses_rs2 && scoreboard[rs2] && !bypass2)
               || (writes_rd && scoreboard[rd]);

  assign in_ready = !reset && !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid && out_ready && !flush;

  always_comb begin
    next_bundle          = bundle;
    next_bundle.instr    = in_instr;
    next_bundle.pc       = in_pc;
    next_bundle.rs1_data = bypass1 ? wb_data : read_data1;
    next_bundle.rs2_data = bypass2 ? wb_data : read_data2;
    next_bundle.rd       = writes_rd ? rd : 5'd0;
  end

  // Set is applied after clear so an issue wins over a same-index writeback
  always_comb begin
    sb_next = scoreboard;
    if (wb_hit)
      sb_next[wb_sel] = 1'b0;
    if (issue && bundle.rd != 5'd0)
      sb_next[bundle.rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      bundle     <= '0;
      scoreboard <= '0;
    end else begin
      scoreboard <= sb_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        bundle    <= next_bundle;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_instr    = bundle.instr;
  assign out_pc       = bundle.pc;
  assign out_rs1_data = bundle.rs1_data;
  assign out_rs2_data = bundle.rs2_data;
  assign out_rd       = bundle.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic against a pending-write set model.
module tb_operand_fetch;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  read_sel1;
  logic [4:0]  read_sel2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        wb_valid;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;

  logic [31:0] rf [32];
  assign read_data1 = rf[read_sel1];
  assign read_data2 = rf[read_sel2];

  operand_fetch dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .read_sel1(read_sel1), .read_sel2(read_sel2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } slot_t;

  // Model: set of registers with an issued but unwritten result, plus the held slot
  bit          pending [32];
  bit          m_vld;
  slot_t       m_slot;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2, output bit w);
    logic [6:0] op;
    op = ins[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111}) && ins[19:15] != 5'd0;
    u2 = (op inside {7'b0110011, 7'b0100011, 7'b1100011}) && ins[24:20] != 5'd0;
    w  = !(op inside {7'b0100011, 7'b1100011}) && ins[11:7] != 5'd0;
  endfunction

  function automatic logic [31:0] pending_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pending[i];
    return v;
  endfunction

  task automatic step(input string tag);
    bit u1, u2, w, f1, f2, stall, exp_rdy, acc, iss;
    int s1, s2, d;
    bit    n_pend [32];
    bit    n_vld;
    slot_t n_slot;
    s1 = int'(in_instr[19:15]);
    s2 = int'(in_instr[24:20]);
    d  = int'(in_instr[11:7]);
    classify(in_instr, u1, u2, w);
    f1 = BYP && u1 && wb_valid && int'(wb_sel) == s1 && pending[s1];
    f2 = BYP && u2 && wb_valid && int'(wb_sel) == s2 && pending[s2];
    stall = (u1 && pending[s1] && !f1) || (u2 && pending[s2] && !f2) || (w && pending[d]);
    exp_rdy = !reset && !flush && !stall && (!m_vld || out_ready);
    #1;
    chk({tag, ":in_ready"}, in_ready, exp_rdy);
    chk({tag, ":read_sel1"}, read_sel1, in_instr[19:15]);
    chk({tag, ":read_sel2"}, read_sel2, in_instr[24:20]);
    acc = in_valid && exp_rdy;
    iss = m_vld && out_ready && !flush;
    n_pend = pending;
    if (wb_valid && wb_sel != 5'd0) n_pend[wb_sel] = 1'b0;
    if (iss && m_slot.rd != 5'd0) n_pend[m_slot.rd] = 1'b1;
    n_vld  = m_vld;
    n_slot = m_slot;
    if (flush) n_vld = 1'b0;
    else if (acc) begin
      n_vld = 1'b1;
      n_slot.instr = in_instr;
      n_slot.pc    = in_pc;
      n_slot.a     = f1 ? wb_data : rf[s1];
      n_slot.b     = f2 ? wb_data : rf[s2];
      n_slot.rd    = w ? in_instr[11:7] : 5'd0;
    end else if (out_ready) n_vld = 1'b0;
    if (reset) begin
      for (int i = 0; i < 32; i++) n_pend[i] = 1'b0;
      n_vld  = 1'b0;
      n_slot = '{32'd0, 32'd0, 32'd0, 32'd0, 5'd0};
    end
    @(posedge clock);
    #1;
    if (wb_valid && wb_sel != 5'd0) rf[wb_sel] = wb_data;
    pending = n_pend;
    m_vld   = n_vld;
    m_slot  = n_slot;
    chk({tag, ":out_valid"}, out_valid, m_vld);
    chk({tag, ":out_instr"}, out_instr, m_slot.instr);
    chk({tag, ":out_pc"}, out_pc, m_slot.pc);
    chk({tag, ":out_rs1"}, out_rs1_data, m_slot.a);
    chk({tag, ":out_rs2"}, out_rs2_data, m_slot.b);
    chk({tag, ":out_rd"}, out_rd, m_slot.rd);
    chk({tag, ":scoreboard"}, dut.scoreboard, pending_vec());
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = in_pc + 32'd4;
    out_ready = ordy;
  endtask

  task automatic wb(input bit v, input logic [4:0] sel, input logic [31:0] dat);
    wb_valid = v;
    wb_sel   = sel;
    wb_data  = dat;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
    return {imm, rs, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 8))
      0: ins[6:0] = 7'b0110011;
      1: ins[6:0] = 7'b0010011;
      2: ins[6:0] = 7'b0000011;
      3: ins[6:0] = 7'b0100011;
      4: ins[6:0] = 7'b1100011;
      5: ins[6:0] = 7'b0110111;
      6: ins[6:0] = 7'b0010111;
      7: ins[6:0] = 7'b1101111;
      default: ins[6:0] = 7'b1100111;
    endcase
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [31:0] add_x3, a_ins, b_ins;
    int r;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? 32'd0 : $urandom;
      pending[i] = 1'b0;
    end
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    m_vld  = 1'b0;
    m_slot = '{32'd0, 32'd0, 32'd0, 32'd0, 5'd0};
    in_pc = 32'h1000;
    drive(1'b0, 32'd0, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    flush = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("reset");
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_scoreboard", dut.scoreboard, 32'd0);
    reset = 1'b0;

    // add x3,x1,x2 then issue it
    add_x3 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    drive(1'b1, add_x3, 1'b1);
    step("add");
    chk("add_rs1", out_rs1_data, 32'd5);
    chk("add_rs2", out_rs2_data, 32'd7);
    chk("add_rd", out_rd, 32'd3);
    drive(1'b0, 32'd0, 1'b1);
    step("add_issue");
    chk("add_sb3", dut.scoreboard[3], 32'd1);

    // addi x4,x3,1 stalls on x3 until its writeback
    drive(1'b1, addi(5'd4, 5'd3, 12'd1), 1'b1);
    step("raw_stall0");
    step("raw_stall1");
    chk("raw_in_ready", in_ready, 32'd0);
    wb(1'b1, 5'd3, 32'd42);
    step("wb3");
    wb(1'b0, 5'd0, 32'd0);
`ifndef WB_BYPASS_EN
    chk("nobyp_held", out_valid, 32'd0);
    step("raw_accept");
`endif
    chk("raw_out_valid", out_valid, 32'd1);
    chk("raw_rs1", out_rs1_data, 32'd42);
    chk("raw_rd", out_rd, 32'd4);
    drive(1'b0, 32'd0, 1'b1);
    step("addi_issue");
    wb(1'b1, 5'd4, $urandom);
    step("wb4");
    wb(1'b0, 5'd0, 32'd0);

    // Hold 4 cycles, then back-to-back replacement
    a_ins = addi(5'd10, 5'd0, 12'd1);
    b_ins = addi(5'd11, 5'd0, 12'd2);
    drive(1'b1, a_ins, 1'b1);
    step("hold_a");
    drive(1'b1, b_ins, 1'b0);
    for (int i = 0; i < 4; i++) step("hold");
    chk("hold_in_ready", in_ready, 32'd0);
    chk("hold_instr", out_instr, a_ins);
    out_ready = 1'b1;
    step("b2b");
    chk("b2b_valid", out_valid, 32'd1);
    chk("b2b_instr", out_instr, b_ins);
    drive(1'b0, 32'd0, 1'b1);
    step("b2b_issue");
    wb(1'b1, 5'd10, $urandom);
    step("wb10");
    wb(1'b1, 5'd11, $urandom);
    step("wb11");
    wb(1'b0, 5'd0, 32'd0);

    // x0 destinations and sources
    drive(1'b1, {7'd0, 5'd5, 5'd0, 3'b010, 5'd0, 7'b0100011}, 1'b1);
    step("sw");
    chk("sw_rd", out_rd, 32'd0);
    drive(1'b1, {20'd1, 5'd0, 7'b0110111}, 1'b1);
    step("lui_x0");
    chk("lui_rd", out_rd, 32'd0);
    drive(1'b1, addi(5'd0, 5'd0, 12'd0), 1'b1);
    step("nop");
    chk("nop_in_ready_next", in_ready, 32'd1);
    drive(1'b0, 32'd0, 1'b1);
    step("x0_drain");
    chk("x0_scoreboard", dut.scoreboard, 32'd0);

    // Issue and writeback on x7 in the same cycle
    drive(1'b1, addi(5'd7, 5'd0, 12'd7), 1'b1);
    step("x7_acc");
    drive(1'b0, 32'd0, 1'b1);
    wb(1'b1, 5'd7, 32'd99);
    step("x7_collide");
    chk("x7_set_wins", dut.scoreboard[7], 32'd1);
    step("x7_clear");
    wb(1'b0, 5'd0, 32'd0);

    // Flush a held bundle
    drive(1'b1, addi(5'd12, 5'd0, 12'd3), 1'b0);
    step("fl_acc");
    drive(1'b0, 32'd0, 1'b0);
    step("fl_hold");
    flush = 1'b1;
    out_ready = 1'b1;
    step("flush");
    flush = 1'b0;
    chk("flush_valid", out_valid, 32'd0);
    chk("flush_sb12", dut.scoreboard[12], 32'd0);

    // Reset in the middle of a stall
    drive(1'b1, addi(5'd13, 5'd0, 12'd4), 1'b1);
    step("rs_acc");
    drive(1'b0, 32'd0, 1'b1);
    step("rs_issue");
    drive(1'b1, addi(5'd14, 5'd13, 12'd1), 1'b1);
    step("rs_stall");
    reset = 1'b1;
    step("rs_reset");
    reset = 1'b0;
    chk("midreset_sb", dut.scoreboard, 32'd0);
    chk("midreset_valid", out_valid, 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7);
      r = $urandom_range(0, 7);
      if ((pending[r] && $urandom_range(0, 1) == 1) || $urandom_range(0, 15) == 0)
        wb(1'b1, 5'(r), $urandom);
      else
        wb(1'b0, 5'($urandom_range(0, 31)), $urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
